// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer that time-shares one external combinational
// adder among NUM_REQ requesters. It grants at most one requester per cycle and drives
// that requester's operands onto the adder. The sum and carry are captured in a
// response register and handed back over a one-hot valid/ready handshake.
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t             state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [WIDTH-1:0]   rsp_sum_r;
  logic               rsp_cout_r;

  logic               drain_s;
  logic               issue_ok_s;
  logic               found_s;
  logic [PW-1:0]      grant_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  int                 idx_s;

  // Round-robin successor of a granted index, wrapping at NUM_REQ.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    if (g == PW'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return g + PW'(1);
    end
  endfunction

  // Detect that the owner of the held response is consuming it this cycle.
  // rsp_valid_r is one-hot, so only the owner's rsp_ready can contribute.
  always_comb begin
    drain_s    = |(rsp_valid_r & rsp_ready);
    issue_ok_s = (state_r == IDLE) || drain_s;
  end

  // Search for the first valid requester starting at rr_ptr_r and wrapping.
  // No grant is issued during reset or while a held response is stalled.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    grant_s     = '0;
    idx_s       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!found_s && rst_n && issue_ok_s && req_valid[idx_s]) begin
        found_s        = 1'b1;
        grant_idx_s    = PW'(idx_s);
        grant_s[idx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Steer the granted requester's operands to the shared adder, zero when idle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (found_s) begin
      add_a   = req_a[int'(grant_idx_s) * WIDTH +: WIDTH];
      add_b   = req_b[int'(grant_idx_s) * WIDTH +: WIDTH];
      add_cin = req_cin[grant_idx_s];
    end else begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
    end
  end

  // Response FSM. An accepted grant captures the adder result and moves the
  // pointer past the winner. A drain with no new grant returns to IDLE but keeps
  // the last sum/carry visible. Otherwise everything holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      rsp_valid_r <= '0;
      rsp_sum_r   <= '0;
      rsp_cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, RESP: begin
          if (found_s) begin
            state_r     <= RESP;
            rr_ptr_r    <= next_ptr(grant_idx_s);
            rsp_valid_r <= grant_s;
            rsp_sum_r   <= add_sum;
            rsp_cout_r  <= add_cout;
          end else if (drain_s) begin
            state_r     <= IDLE;
            rsp_valid_r <= '0;
          end else begin
            state_r     <= state_r;
            rsp_valid_r <= rsp_valid_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= '0;
        end
      endcase
    end
  end

  // Outputs come straight from registers, except the grant, which must be combinational.
  always_comb begin
    req_ready = grant_s;
    rsp_valid = rsp_valid_r;
    rsp_sum   = rsp_sum_r;
    rsp_cout  = rsp_cout_r;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter. The bench models the external adder itself.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked on the
// falling edge.
module tb_adder_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [W-1:0] exp_sums [3];

  always #5 clk = ~clk;

  // Model of the external combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = '0;

    // Reset state: request pending but nothing granted while rst_n is low.
    tick();
    set_op(0, 32'd1, 32'd2, 1'b0);
    req_valid = 3'b001;
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // Test 1: a single request.
    tick();
    rst_n     = 1'b1;
    rsp_ready = 3'b111;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'd1);
    chk("t1_add_a", 64'(add_a), 64'd1);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_sum", 64'(rsp_sum), 64'd3);
    chk("t1_cout", 64'(rsp_cout), 64'd0);
    chk("t1_no_ready", 64'(req_ready), 64'd0);

    // Test 2: carry-out, then carry-in, issued back to back on req1.
    tick();
    set_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid = 3'b010;
    @(negedge clk);
    chk("t2_ready", 64'(req_ready), 64'd2);
    tick();
    set_op(1, 32'd5, 32'd6, 1'b1);
    @(negedge clk);
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd2);
    chk("t2_sum_wrap", 64'(rsp_sum), 64'd0);
    chk("t2_cout", 64'(rsp_cout), 64'd1);
    chk("t2_b2b_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("t2_sum_cin", 64'(rsp_sum), 64'd12);
    chk("t2_cout0", 64'(rsp_cout), 64'd0);

    // Test 3: three-way contention right after reset.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(0, 32'd10, 32'd20, 1'b0);
    set_op(1, 32'd100, 32'd200, 1'b1);
    set_op(2, 32'd1000, 32'd2000, 1'b0);
    exp_sums[0] = 32'd30;
    exp_sums[1] = 32'd301;
    exp_sums[2] = 32'd3000;
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t3_grant%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      if (c > 0) begin
        chk($sformatf("t3_rspv%0d", c), 64'(rsp_valid), 64'(3'b001 << ((c - 1) % 3)));
        chk($sformatf("t3_sum%0d", c), 64'(rsp_sum), 64'(exp_sums[(c - 1) % 3]));
      end
      tick();
    end

    // Test 4: owner (req2) withholds rsp_ready for 3 cycles. The others' ready is ignored.
    rsp_ready = 3'b011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t4_stall_ready%0d", c), 64'(req_ready), 64'd0);
      chk($sformatf("t4_hold_valid%0d", c), 64'(rsp_valid), 64'd4);
      chk($sformatf("t4_hold_sum%0d", c), 64'(rsp_sum), 64'd3000);
      tick();
    end
    rsp_ready = 3'b111;
    @(negedge clk);
    chk("t4_drain_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("t4_next_valid", 64'(rsp_valid), 64'd1);
    chk("t4_next_sum", 64'(rsp_sum), 64'd30);

    // Test 5: grant req2 alone, then req0 and req2 compete. The pointer has wrapped to 0.
    tick();
    set_op(2, 32'd7, 32'd8, 1'b0);
    req_valid = 3'b100;
    @(negedge clk);
    chk("t5_grant2", 64'(req_ready), 64'd4);
    tick();
    req_valid = 3'b101;
    @(negedge clk);
    chk("t5_sum15", 64'(rsp_sum), 64'd15);
    chk("t5_wrap_grant0", 64'(req_ready), 64'd1);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("t5_rsp0", 64'(rsp_valid), 64'd1);

    // Test 6: reset while a response to req1 is held.
    tick();
    req_valid = 3'b010;
    rsp_ready = 3'b000;
    @(negedge clk);
    chk("t6_grant1", 64'(req_ready), 64'd2);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("t6_held", 64'(rsp_valid), 64'd2);
    chk("t6_held_sum", 64'(rsp_sum), 64'd301);
    tick();
    rst_n     = 1'b0;
    req_valid = 3'b101;
    @(negedge clk);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 3'b111;
    @(negedge clk);
    chk("t6_rsp_cleared", 64'(rsp_valid), 64'd0);
    chk("t6_sum_cleared", 64'(rsp_sum), 64'd0);
    chk("t6_cout_cleared", 64'(rsp_cout), 64'd0);
    chk("t6_grant0_first", 64'(req_ready), 64'd1);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk("t6_post_valid", 64'(rsp_valid), 64'd1);
    chk("t6_post_sum", 64'(rsp_sum), 64'd30);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
